// File: rtl/game_sequencer.sv
// Beat-level play controller for the arrow game: countdown, per-beat hit window,
// hit judgement, score/combo/miss bookkeeping and the game-over condition.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | no game; counters held at zero, waiting for start
// COUNT  | countdown beats before play; hits ignored
// PLAY   | arrows advance on every beat; hits judged once per window
// PAUSE  | game frozen; window and judged flag preserved
// OVER   | miss limit reached; counters frozen until start
module game_sequencer #(
    parameter int SCORE_W         = 14,
    parameter int SCORE_MAX       = 9999,
    parameter int MAX_MISSES      = 8,
    parameter int COUNTDOWN_BEATS = 4,
    parameter int BONUS_STEP      = 10
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               beat_tick,
    input  logic               start,
    input  logic               pause,
    input  logic               arrow_valid,
    input  logic               correct_hit,
    input  logic               incorrect_hit,
    output logic               shift_en,
    output logic               window_open,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] combo,
    output logic [3:0]         misses,
    output logic [2:0]         game_state,
    output logic               game_over
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_COUNT = 3'd1,
        S_PLAY  = 3'd2,
        S_PAUSE = 3'd3,
        S_OVER  = 3'd4
    } state_t;

    localparam logic [SCORE_W-1:0] SMAX     = SCORE_W'(SCORE_MAX);
    localparam logic [SCORE_W-1:0] BSTEP    = SCORE_W'(BONUS_STEP);
    localparam logic [3:0]         MISS_MAX = 4'(MAX_MISSES);
    localparam logic [3:0]         CNT_LOAD = 4'(COUNTDOWN_BEATS);

    state_t               state_q, state_d;
    logic [3:0]           beat_cnt_q, beat_cnt_d;
    logic                 judged_q, judged_d;
    logic [SCORE_W-1:0]   score_d, combo_d;
    logic [3:0]           misses_d;
    logic                 shift_en_d, window_d;
    logic                 hit_ev, judge_now, good_hit, miss_now;
    logic [SCORE_W-1:0]   bonus;
    logic [SCORE_W:0]     score_sum;

    assign hit_ev     = correct_hit | incorrect_hit;
    assign bonus      = combo / BSTEP;
    assign score_sum  = {1'b0, score} + {1'b0, bonus} + {{SCORE_W{1'b0}}, 1'b1};
    assign game_state = state_q;

    // Next-state, judgement and counter update logic.
    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        judged_d   = judged_q;
        score_d    = score;
        combo_d    = combo;
        misses_d   = misses;
        shift_en_d = 1'b0;
        window_d   = window_open;
        judge_now  = 1'b0;
        good_hit   = 1'b0;
        miss_now   = 1'b0;
        case (state_q)
            S_IDLE: begin
                score_d  = '0;
                combo_d  = '0;
                misses_d = '0;
                window_d = 1'b0;
                judged_d = 1'b0;
                if (start) begin
                    state_d    = S_COUNT;
                    beat_cnt_d = CNT_LOAD;
                end
            end
            S_COUNT: begin
                if (beat_tick) begin
                    if (beat_cnt_q <= 4'd1) begin
                        state_d    = S_PLAY;
                        beat_cnt_d = '0;
                        shift_en_d = 1'b1;
                        window_d   = 1'b1;
                        judged_d   = 1'b0;
                    end else begin
                        beat_cnt_d = beat_cnt_q - 4'd1;
                    end
                end
            end
            S_PLAY: begin
                if (pause) begin
                    state_d = S_PAUSE;
                end else begin
                    // A hit on the tick cycle is judged against the closing window first.
                    judge_now = hit_ev & window_open & ~judged_q;
                    if (judge_now) begin
                        judged_d = 1'b1;
                        if (correct_hit && !incorrect_hit && arrow_valid)
                            good_hit = 1'b1;
                        else
                            miss_now = 1'b1;
                    end
                    if (beat_tick) begin
                        if (arrow_valid && !judged_q && !judge_now)
                            miss_now = 1'b1;
                        shift_en_d = 1'b1;
                        window_d   = 1'b1;
                        judged_d   = 1'b0;
                    end
                    if (good_hit) begin
                        combo_d = (combo >= SMAX) ? SMAX : combo + 1'b1;
                        score_d = (score_sum >= {1'b0, SMAX}) ? SMAX : score_sum[SCORE_W-1:0];
                    end
                    if (miss_now) begin
                        combo_d  = '0;
                        misses_d = misses + 4'd1;
                        if (misses_d >= MISS_MAX) begin
                            misses_d   = MISS_MAX;
                            state_d    = S_OVER;
                            shift_en_d = 1'b0;
                            window_d   = 1'b0;
                        end
                    end
                end
            end
            S_PAUSE: begin
                if (!pause)
                    state_d = S_PLAY;
            end
            S_OVER: begin
                window_d = 1'b0;
                if (start) begin
                    state_d    = S_COUNT;
                    beat_cnt_d = CNT_LOAD;
                    score_d    = '0;
                    combo_d    = '0;
                    misses_d   = '0;
                    judged_d   = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            beat_cnt_q  <= '0;
            judged_q    <= 1'b0;
            score       <= '0;
            combo       <= '0;
            misses      <= '0;
            shift_en    <= 1'b0;
            window_open <= 1'b0;
            game_over   <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_cnt_q  <= beat_cnt_d;
            judged_q    <= judged_d;
            score       <= score_d;
            combo       <= combo_d;
            misses      <= misses_d;
            shift_en    <= shift_en_d;
            window_open <= window_d;
            game_over   <= (state_d == S_OVER);
        end
    end

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer: countdown, judgement, misses, game over,
// simultaneous hits, pause and score saturation.
module tb_game_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        beat_tick, start, pause, arrow_valid, correct_hit, incorrect_hit;
    logic        shift_en, window_open, game_over;
    logic [13:0] score, combo;
    logic [3:0]  misses;
    logic [2:0]  game_state;

    int n_vec = 0;
    int n_err = 0;
    int exp_score, exp_combo;

    game_sequencer dut (
        .clk(clk), .reset_n(reset_n), .beat_tick(beat_tick), .start(start),
        .pause(pause), .arrow_valid(arrow_valid), .correct_hit(correct_hit),
        .incorrect_hit(incorrect_hit), .shift_en(shift_en), .window_open(window_open),
        .score(score), .combo(combo), .misses(misses), .game_state(game_state),
        .game_over(game_over)
    );

    always #5 clk = ~clk;

    // Advance one clock; outputs are stable 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        beat_tick = 1'b1; step(); beat_tick = 1'b0;
    endtask

    task automatic hit();
        correct_hit = 1'b1; step(); correct_hit = 1'b0;
    endtask

    task automatic countdown();
        start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
    endtask

    task automatic test_reset();
        n_vec++; if (game_state !== 3'd0) begin n_err++; $display("FAIL rst_state: got %0d want 0", game_state); end
        n_vec++; if (score !== 14'd0) begin n_err++; $display("FAIL rst_score: got %0d want 0", score); end
        n_vec++; if (combo !== 14'd0 || misses !== 4'd0) begin n_err++; $display("FAIL rst_counters: combo %0d misses %0d want 0 0", combo, misses); end
        n_vec++; if (shift_en !== 1'b0 || window_open !== 1'b0 || game_over !== 1'b0) begin n_err++; $display("FAIL rst_flags: shift %b win %b over %b want 000", shift_en, window_open, game_over); end
        pause = 1'b1; step(); pause = 1'b0;
        n_vec++; if (game_state !== 3'd0) begin n_err++; $display("FAIL idle_pause: got %0d want 0", game_state); end
    endtask

    task automatic test_countdown();
        start = 1'b1; step(); start = 1'b0;
        n_vec++; if (game_state !== 3'd1) begin n_err++; $display("FAIL count_enter: got %0d want 1", game_state); end
        arrow_valid = 1'b1; hit();
        n_vec++; if (combo !== 14'd0 || score !== 14'd0) begin n_err++; $display("FAIL count_hit_ignored: combo %0d score %0d want 0 0", combo, score); end
        for (int i = 1; i <= 4; i++) begin
            tick();
            if (i < 4) begin
                n_vec++; if (game_state !== 3'd1 || shift_en !== 1'b0) begin n_err++; $display("FAIL count_tick%0d: state %0d shift %b want 1 0", i, game_state, shift_en); end
            end else begin
                n_vec++; if (game_state !== 3'd2 || shift_en !== 1'b1 || window_open !== 1'b1) begin n_err++; $display("FAIL count_play: state %0d shift %b win %b want 2 1 1", game_state, shift_en, window_open); end
            end
        end
        step();
        n_vec++; if (shift_en !== 1'b0) begin n_err++; $display("FAIL shift_one_clk: got %b want 0", shift_en); end
    endtask

    task automatic test_hits();
        arrow_valid = 1'b1;
        for (int i = 0; i < 19; i++) begin hit(); tick(); end
        n_vec++; if (combo !== 14'd19 || score !== 14'd28) begin n_err++; $display("FAIL hits19: combo %0d score %0d want 19 28", combo, score); end
        hit();
        n_vec++; if (combo !== 14'd20 || score !== 14'd30) begin n_err++; $display("FAIL hit_bonus: combo %0d score %0d want 20 30", combo, score); end
        hit();
        n_vec++; if (combo !== 14'd20 || score !== 14'd30) begin n_err++; $display("FAIL second_hit: combo %0d score %0d want 20 30", combo, score); end
        incorrect_hit = 1'b1; step(); incorrect_hit = 1'b0;
        n_vec++; if (misses !== 4'd0 || combo !== 14'd20) begin n_err++; $display("FAIL late_wrong: misses %0d combo %0d want 0 20", misses, combo); end
        start = 1'b1; step(); start = 1'b0;
        n_vec++; if (game_state !== 3'd2) begin n_err++; $display("FAIL play_start: got %0d want 2", game_state); end
        tick();
        n_vec++; if (misses !== 4'd0 || shift_en !== 1'b1) begin n_err++; $display("FAIL judged_tick: misses %0d shift %b want 0 1", misses, shift_en); end
        incorrect_hit = 1'b1; step(); incorrect_hit = 1'b0;
        n_vec++; if (misses !== 4'd1 || combo !== 14'd0 || score !== 14'd30) begin n_err++; $display("FAIL wrong_hit: misses %0d combo %0d score %0d want 1 0 30", misses, combo, score); end
        tick();
        for (int i = 0; i < 7; i++) begin hit(); tick(); end
        n_vec++; if (score !== 14'd37 || combo !== 14'd7) begin n_err++; $display("FAIL score37: score %0d combo %0d want 37 7", score, combo); end
    endtask

    task automatic test_reset_mid_play();
        reset_n = 1'b0; step();
        n_vec++; if (game_state !== 3'd0 || score !== 14'd0 || combo !== 14'd0 || misses !== 4'd0 || shift_en !== 1'b0) begin
            n_err++; $display("FAIL mid_reset: state %0d score %0d combo %0d misses %0d shift %b want 0 0 0 0 0", game_state, score, combo, misses, shift_en); end
        reset_n = 1'b1; step();
        n_vec++; if (game_state !== 3'd0) begin n_err++; $display("FAIL post_reset: got %0d want 0", game_state); end
    endtask

    task automatic test_misses();
        arrow_valid = 1'b1;
        countdown();
        hit(); tick();
        n_vec++; if (combo !== 14'd1 || misses !== 4'd0) begin n_err++; $display("FAIL miss_pre: combo %0d misses %0d want 1 0", combo, misses); end
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k == 1) begin
                n_vec++; if (misses !== 4'd1 || combo !== 14'd0) begin n_err++; $display("FAIL nopress: misses %0d combo %0d want 1 0", misses, combo); end
            end
            if (k == 7) begin
                n_vec++; if (misses !== 4'd7 || game_state !== 3'd2) begin n_err++; $display("FAIL miss7: misses %0d state %0d want 7 2", misses, game_state); end
            end
        end
        n_vec++; if (game_state !== 3'd4 || game_over !== 1'b1 || misses !== 4'd8) begin n_err++; $display("FAIL over: state %0d over %b misses %0d want 4 1 8", game_state, game_over, misses); end
        n_vec++; if (shift_en !== 1'b0 || window_open !== 1'b0) begin n_err++; $display("FAIL over_flags: shift %b win %b want 0 0", shift_en, window_open); end
        correct_hit = 1'b1; beat_tick = 1'b1; pause = 1'b1; step();
        correct_hit = 1'b0; beat_tick = 1'b0; pause = 1'b0;
        n_vec++; if (game_state !== 3'd4 || misses !== 4'd8 || shift_en !== 1'b0 || combo !== 14'd0) begin n_err++; $display("FAIL over_frozen: state %0d misses %0d shift %b combo %0d want 4 8 0 0", game_state, misses, shift_en, combo); end
    endtask

    task automatic test_simultaneous();
        start = 1'b1; step(); start = 1'b0;
        n_vec++; if (game_state !== 3'd1 || misses !== 4'd0 || game_over !== 1'b0) begin n_err++; $display("FAIL restart: state %0d misses %0d over %b want 1 0 0", game_state, misses, game_over); end
        for (int i = 0; i < 4; i++) tick();
        hit(); tick();
        correct_hit = 1'b1; incorrect_hit = 1'b1; step(); correct_hit = 1'b0; incorrect_hit = 1'b0;
        n_vec++; if (misses !== 4'd1 || combo !== 14'd0 || score !== 14'd1) begin n_err++; $display("FAIL both_hits: misses %0d combo %0d score %0d want 1 0 1", misses, combo, score); end
        tick();
        correct_hit = 1'b1; beat_tick = 1'b1; step(); correct_hit = 1'b0; beat_tick = 1'b0;
        n_vec++; if (misses !== 4'd1 || combo !== 14'd1 || score !== 14'd2 || shift_en !== 1'b1) begin n_err++; $display("FAIL hit_on_tick: misses %0d combo %0d score %0d shift %b want 1 1 2 1", misses, combo, score, shift_en); end
        hit();
        n_vec++; if (combo !== 14'd2 || score !== 14'd3) begin n_err++; $display("FAIL fresh_window: combo %0d score %0d want 2 3", combo, score); end
        tick();
        arrow_valid = 1'b0; hit();
        n_vec++; if (misses !== 4'd2 || combo !== 14'd0 || score !== 14'd3) begin n_err++; $display("FAIL hit_no_arrow: misses %0d combo %0d score %0d want 2 0 3", misses, combo, score); end
        tick(); arrow_valid = 1'b1;
    endtask

    task automatic test_pause();
        pause = 1'b1; step();
        n_vec++; if (game_state !== 3'd3) begin n_err++; $display("FAIL pause_enter: got %0d want 3", game_state); end
        for (int i = 0; i < 3; i++) begin
            beat_tick = 1'b1; correct_hit = (i == 1); step(); beat_tick = 1'b0; correct_hit = 1'b0;
            n_vec++; if (shift_en !== 1'b0) begin n_err++; $display("FAIL pause_shift%0d: got %b want 0", i, shift_en); end
        end
        n_vec++; if (score !== 14'd3 || combo !== 14'd0 || misses !== 4'd2 || window_open !== 1'b1 || game_state !== 3'd3) begin
            n_err++; $display("FAIL pause_frozen: score %0d combo %0d misses %0d win %b state %0d want 3 0 2 1 3", score, combo, misses, window_open, game_state); end
        pause = 1'b0; step();
        n_vec++; if (game_state !== 3'd2) begin n_err++; $display("FAIL resume: got %0d want 2", game_state); end
        hit();
        n_vec++; if (combo !== 14'd1 || score !== 14'd4) begin n_err++; $display("FAIL resume_hit: combo %0d score %0d want 1 4", combo, score); end
        tick();
    endtask

    task automatic test_saturation();
        exp_score = 4; exp_combo = 1;
        for (int i = 0; i < 3000 && exp_score != 9999; i++) begin
            correct_hit = 1'b1; beat_tick = 1'b1; step();
            exp_score = exp_score + 1 + exp_combo / 10;
            if (exp_score > 9999) exp_score = 9999;
            exp_combo++;
        end
        correct_hit = 1'b0; beat_tick = 1'b0;
        n_vec++; if (score !== 14'd9999 || combo !== 14'(exp_combo)) begin n_err++; $display("FAIL sat_reach: score %0d combo %0d want 9999 %0d", score, combo, exp_combo); end
        hit();
        n_vec++; if (score !== 14'd9999 || combo !== 14'(exp_combo + 1) || misses !== 4'd2) begin n_err++; $display("FAIL sat_hold: score %0d combo %0d misses %0d want 9999 %0d 2", score, combo, misses, exp_combo + 1); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n = 1'b0; beat_tick = 1'b0; start = 1'b0; pause = 1'b0;
        arrow_valid = 1'b0; correct_hit = 1'b0; incorrect_hit = 1'b0;
        step(); step();
        reset_n = 1'b1;
        test_reset();
        test_countdown();
        test_hits();
        test_reset_mid_play();
        test_misses();
        test_simultaneous();
        test_pause();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
